// File: rtl/store_write_buffer_if.sv
// Store write buffer bus bundle.
// Groups the store-write input, forwarding lookup and memory drain handshake.
//   slave  : the buffer itself (takes wr_*/rd_addr/mem_ack, drives status, fwd, mem_*)
//   master : the pipeline/memory side driving the buffer
interface store_write_buffer_if #(
  parameter int CNT_W = 3
);
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [3:0]       wr_byteen;
  logic [31:0]      wr_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_fwd_data;
  logic [3:0]       rd_fwd_mask;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_byteen;
  logic [31:0]      mem_wdata;
  logic             mem_ack;

  modport slave (
    input  wr_en, wr_addr, wr_byteen, wr_data, rd_addr, mem_ack,
    output full, empty, count, rd_fwd_data, rd_fwd_mask,
           mem_req, mem_addr, mem_byteen, mem_wdata
  );

  modport master (
    output wr_en, wr_addr, wr_byteen, wr_data, rd_addr, mem_ack,
    input  full, empty, count, rd_fwd_data, rd_fwd_mask,
           mem_req, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer for the MEM stage.
// Queues byte-enabled stores in a DEPTH-entry FIFO, drains the head to data memory
// over mem_req/mem_ack, and forwards pending bytes (youngest match per lane) to loads.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous reset, active-low
//   bus    store_write_buffer_if.slave (wr_*, full/empty/count, rd_addr/rd_fwd_*, mem_*)
// Optional feature: define STORE_MERGE_EN to merge a store into the youngest entry when
// its word address matches (never into a head that is being requested).

// Per-lane forwarding select: highest age index (youngest) hitting entry wins.
module swb_fwd_lane #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]      hit,
  input  logic [DEPTH-1:0]      be,
  input  logic [DEPTH-1:0][7:0] bytes,
  output logic [7:0]            fwd_byte,
  output logic                  fwd_en
);
  always_comb begin
    fwd_byte = '0;
    fwd_en   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit[k] && be[k]) begin
        fwd_byte = bytes[k];
        fwd_en   = 1'b1;
      end
    end
  end
endmodule

module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [29:0] wa;
    logic [3:0]  be;
    logic [31:0] data;
  } swb_entry_t;

  swb_entry_t [DEPTH-1:0] ent;
  logic [PTR_W-1:0]       head, tail, youngest;
  logic [CNT_W-1:0]       cnt;
  logic                   wr_vld, merge, alloc, pop;
  swb_entry_t             head_e, merge_e;

  assign bus.count = cnt;
  assign bus.full  = (cnt == CNT_W'(DEPTH));
  assign bus.empty = (cnt == '0);

  // Drain side: outputs forced to zero when idle so they read as 0 out of reset.
  assign head_e         = ent[head];
  assign bus.mem_req    = !bus.empty;
  assign bus.mem_addr   = bus.mem_req ? {head_e.wa, 2'b00} : '0;
  assign bus.mem_byteen = bus.mem_req ? head_e.be : '0;
  assign bus.mem_wdata  = bus.mem_req ? head_e.data : '0;

  assign pop      = bus.mem_ack && bus.mem_req;
  assign wr_vld   = bus.wr_en && (bus.wr_byteen != '0);
  assign youngest = tail - PTR_W'(1);

`ifdef STORE_MERGE_EN
  // Head may only absorb a merge while it is not being offered to memory.
  assign merge = wr_vld && !bus.empty && (ent[youngest].wa == bus.wr_addr[31:2]) &&
                 ((cnt >= CNT_W'(2)) || !bus.mem_req);
`else
  assign merge = 1'b0;
`endif
  assign alloc = wr_vld && !bus.full && !merge;

  always_comb begin
    merge_e    = ent[youngest];
    merge_e.be = ent[youngest].be | bus.wr_byteen;
    for (int i = 0; i < NUM_LANES; i++)
      if (bus.wr_byteen[i]) merge_e.data[8*i +: 8] = bus.wr_data[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      ent  <= '0;
    end else begin
      if (alloc) begin
        ent[tail] <= '{wa: bus.wr_addr[31:2], be: bus.wr_byteen, data: bus.wr_data};
        tail      <= tail + PTR_W'(1);
      end
      if (merge) ent[youngest] <= merge_e;
      if (pop)   head <= head + PTR_W'(1);
      cnt <= cnt + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  // Forwarding: entries re-ordered by age (0 = head/oldest) so lanes pick the highest hit.
  swb_entry_t [DEPTH-1:0]         age;
  logic [DEPTH-1:0]               hit;
  logic [NUM_LANES-1:0][7:0]      fwd_data;
  logic [NUM_LANES-1:0]           fwd_mask;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age[k] = ent[head + PTR_W'(k)];
    assign hit[k] = (CNT_W'(k) < cnt) && (age[k].wa == bus.rd_addr[31:2]);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DEPTH-1:0]      be_bit;
    logic [DEPTH-1:0][7:0] bytes;
    for (genvar k = 0; k < DEPTH; k++) begin : g_src
      assign be_bit[k] = age[k].be[l];
      assign bytes[k]  = age[k].data[8*l +: 8];
    end
    swb_fwd_lane #(.DEPTH(DEPTH)) u_lane (
      .hit      (hit),
      .be       (be_bit),
      .bytes    (bytes),
      .fwd_byte (fwd_data[l]),
      .fwd_en   (fwd_mask[l])
    );
  end

  assign bus.rd_fwd_data = fwd_data;
  assign bus.rd_fwd_mask = fwd_mask;

  logic unused_lsb;
  assign unused_lsb = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};
endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_write_buffer_if #(.CNT_W(3)) bus();

  store_write_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input bit exp_q);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = a;
    bus.wr_byteen = be;
    bus.wr_data   = d;
    tick;
    bus.wr_en = 1'b0;
    if (exp_q) sb.push_back('{a & 32'hFFFF_FFFC, be, d});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    bus.mem_ack = 1'b1;
    while (!bus.empty && n < 10) begin
      tick;
      n++;
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_empty"}, 32'(bus.empty), 32'd1);
    chk({nm, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: every accepted memory write must match the next expected store.
  always @(negedge clk) begin
    if (reset && bus.mem_req && bus.mem_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got addr 0x%08h expected no write", bus.mem_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("drain_addr", bus.mem_addr, mon_e.a);
        chk("drain_byteen", 32'(bus.mem_byteen), 32'(mon_e.be));
        chk("drain_wdata", bus.mem_wdata, mon_e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_byteen = '0;
    bus.wr_data   = '0;
    bus.rd_addr   = '0;
    bus.mem_ack   = 1'b0;
    #3;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick;

    // 1: asynchronous reset while entries are waiting to drain
    push(32'h10, 4'hF, 32'h0000_0001, 1'b0);
    push(32'h20, 4'hF, 32'h0000_0002, 1'b0);
    push(32'h30, 4'hF, 32'h0000_0003, 1'b0);
    @(negedge clk);
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_rst_count", 32'(bus.count), 32'd0);
    chk("t1_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t1_rst_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick;

    // 2: head held stable while mem_ack low, then popped
    push(32'h100, 4'b1111, 32'hAABB_CCDD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_req", 32'(bus.mem_req), 32'd1);
      chk("t2_hold_addr", bus.mem_addr, 32'h100);
      chk("t2_hold_byteen", 32'(bus.mem_byteen), 32'hF);
      chk("t2_hold_wdata", bus.mem_wdata, 32'hAABB_CCDD);
      tick;
    end
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t2_empty", 32'(bus.empty), 32'd1);
    chk("t2_mem_req", 32'(bus.mem_req), 32'd0);
    tick;
    bus.mem_ack = 1'b1;            // ack with nothing requested must be ignored
    tick;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t2_idle_ack_count", 32'(bus.count), 32'd0);
    tick;

    // 3: fill, then push while full with a simultaneous pop
    push(32'h1000, 4'hF, 32'hB000_0000, 1'b1);
    push(32'h1004, 4'hF, 32'hB000_0001, 1'b1);
    push(32'h1008, 4'hF, 32'hB000_0002, 1'b1);
    push(32'h100C, 4'hF, 32'hB000_0003, 1'b1);
    @(negedge clk);
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_count4", 32'(bus.count), 32'd4);
    tick;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 32'h2000;
    bus.wr_byteen = 4'hF;
    bus.wr_data   = 32'hDEAD_0000;
    bus.mem_ack   = 1'b1;
    tick;
    bus.wr_en   = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("t3_count3", 32'(bus.count), 32'd3);
    chk("t3_not_full", 32'(bus.full), 32'd0);
    tick;
    drain("t3");
    tick;

    // 4: per-lane youngest-wins forwarding
    push(32'h200, 4'b0001, 32'h0000_0011, 1'b1);
    push(32'h200, 4'b0100, 32'h0022_0000, 1'b1);
`ifdef STORE_MERGE_EN
    push(32'h200, 4'b0001, 32'h0000_0033, 1'b0);
    sb[sb.size()-1].be = 4'b0101;
    sb[sb.size()-1].d  = 32'h0022_0033;
`else
    push(32'h200, 4'b0001, 32'h0000_0033, 1'b1);
`endif
    bus.rd_addr = 32'h202;
    @(negedge clk);
    chk("t4_fwd_mask", 32'(bus.rd_fwd_mask), 32'b0101);
    chk("t4_fwd_data", bus.rd_fwd_data, 32'h0022_0033);
`ifdef STORE_MERGE_EN
    chk("t4_count", 32'(bus.count), 32'd2);
`else
    chk("t4_count", 32'(bus.count), 32'd3);
`endif

    // 5: no match, and same-cycle store is not forwarded until the next cycle
    tick;
    bus.rd_addr   = 32'h300;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 32'h300;
    bus.wr_byteen = 4'hF;
    bus.wr_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t5_nofwd_mask", 32'(bus.rd_fwd_mask), 32'd0);
    chk("t5_nofwd_data", bus.rd_fwd_data, 32'd0);
    tick;
    bus.wr_en = 1'b0;
    sb.push_back('{32'h300, 4'hF, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("t5_next_mask", 32'(bus.rd_fwd_mask), 32'hF);
    chk("t5_next_data", bus.rd_fwd_data, 32'hDEAD_BEEF);
    tick;
    drain("t5");
    tick;

    // 6: two stores to the same word behind another entry
    push(32'h500, 4'hF, 32'h5555_5555, 1'b1);
    push(32'h400, 4'b0011, 32'h0000_1111, 1'b1);
`ifdef STORE_MERGE_EN
    push(32'h400, 4'b1100, 32'h2222_0000, 1'b0);
    sb[sb.size()-1].be = 4'b1111;
    sb[sb.size()-1].d  = 32'h2222_1111;
`else
    push(32'h400, 4'b1100, 32'h2222_0000, 1'b1);
`endif
    bus.rd_addr = 32'h400;
    @(negedge clk);
    chk("t6_fwd_mask", 32'(bus.rd_fwd_mask), 32'hF);
    chk("t6_fwd_data", bus.rd_fwd_data, 32'h2222_1111);
`ifdef STORE_MERGE_EN
    chk("t6_count", 32'(bus.count), 32'd2);
`else
    chk("t6_count", 32'(bus.count), 32'd3);
`endif
    tick;
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
